// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: one 16x16 unsigned multiplier shared by NUM_REQ requesters.
// A round-robin arbiter picks one valid requester per operation, captures its
// operands, multiplies them in the following cycle, and holds the tagged product
// on a single response channel until the consumer takes it.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  output logic [31:0]             resp_prod,
  output logic [IDW-1:0]          resp_id,
  input  logic                    resp_ready,
  output logic                    busy
);

  localparam int OPW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OPW-1:0]   a_q, a_d;
  logic [OPW-1:0]   b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [2*OPW-1:0] resp_prod_q, resp_prod_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [OPW-1:0]   a_sel;
  logic [OPW-1:0]   b_sel;
  logic [2*OPW-1:0] prod;

  // Full-width unsigned product; the shared multiplier instance.
  function automatic logic [2*OPW-1:0] mul_full(input logic [OPW-1:0] x,
                                                input logic [OPW-1:0] y);
    return (2*OPW)'(x) * (2*OPW)'(y);
  endfunction

  // Next index after g, wrapping NUM_REQ-1 back to 0 (NUM_REQ need not be a power of 2).
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] g);
    if (g == IDW'(NUM_REQ - 1)) begin
      return '0;
    end
    return g + IDW'(1);
  endfunction

  assign prod = mul_full(a_q, b_q);

  // Round-robin search starting at rr_ptr; also muxes out the winner's operands.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        a_sel = req_a[OPW*k +: OPW];
        b_sel = req_b[OPW*k +: OPW];
      end
    end
  end

  // One-hot accept, only while idle; held low during reset since nothing is latched then.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == IDLE) && grant_found) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_idx == IDW'(k)) begin
          req_ready[k] = 1'b1;
        end
      end
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_prod_d  = resp_prod_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d      = a_sel;
          b_d      = b_sel;
          id_d     = grant_idx;
          rr_ptr_d = next_idx(grant_idx);
          state_d  = MUL;
        end
      end
      MUL: begin
        resp_prod_d  = prod;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Product and id stay frozen until the consumer accepts.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and data registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_prod_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_prod_q  <= resp_prod_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_prod  = resp_prod_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule
